axi_refill_read_arbiter: RTL
============================

Name: axi_refill_read_arbiter

Overview:
- Shares one AXI3 read port (AR + R channels) between the I-cache and D-cache refill engines.
- Round-robin arbitration with one burst outstanding at a time.
- Registers the winning request, issues it on AR, then steers every R beat to the owner until rlast.
- Sits between both cache refill FSMs and the core's AXI read master interface.

Parameters:
- INST_ID, 4'd0, arid driven for I-cache bursts
- DATA_ID, 4'd1, arid driven for D-cache bursts

Ports:
- aclk  input  1  clock
- aresetn  input  1  async active-low reset
- inst_arvalid, data_arvalid  input  1  refill request
- inst_arready, data_arready  output  1  request accepted
- inst_araddr, data_araddr  input  32  burst start address
- inst_arlen, data_arlen  input  8  beats minus 1
- inst_arsize, data_arsize  input  3  beat size
- inst_rdata, data_rdata  output  32  read data (rdata fanout)
- inst_rresp, data_rresp  output  2  rresp fanout
- inst_rlast, data_rlast  output  1  last beat, owner only
- inst_rvalid, data_rvalid  output  1  beat valid, owner only
- inst_rready, data_rready  input  1  master accepts beat
- arid  output  4  INST_ID or DATA_ID
- araddr / arlen / arsize  output  32/8/3  latched request fields
- arburst / arlock / arcache / arprot  output  2/2/4/3  constants 2'b01, 0, 0, 0
- arvalid  output  1  AR valid
- arready  input  1  AR accepted
- rid  input  4  read id
- rdata / rresp  input  32/2  read data / response
- rlast / rvalid  input  1  last beat / beat valid
- rready  output  1  owner's rready while in R_DATA, else 0
- busy  output  1  state != IDLE
- proto_err  output  1  sticky protocol error

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE, arvalid=0, all *_arready=0, all *_rvalid=0, rready=0, busy=0, proto_err=0.
  - last_grant=DATA, so inst wins the first tie.
  - Latched fields and beat counter cleared.
- FSM states:
  - IDLE:
    - If exactly one *_arvalid=1, grant that master.
    - If both are 1, grant the master not equal to last_grant.
    - On grant, in the same cycle:
      - Pulse the winner's *_arready=1 (combinational on grant, IDLE only).
      - Latch addr/len/size and owner.
      - Set arid, update last_grant, go to AR.
    - The loser's arready stays 0; its request stays pending.
  - AR:
    - arvalid=1 with stable latched fields.
    - On arready=1, clear the beat counter and go to R_DATA.
    - arvalid is never dropped before arready.
  - R_DATA:
    - owner_rvalid=rvalid and rready=owner_rready; the non-owner rvalid/rlast stay 0.
    - rdata/rresp are broadcast to both masters.
    - Each handshake (rvalid&rready) increments an 8-bit beat counter.
    - On a handshake with rlast=1, go to IDLE. A new grant is possible the next cycle, so minimum gap between bursts = 1 idle cycle.
- Latency:
  - Request to arvalid: 1 cycle.
  - R beats: zero added latency (combinational steering).
- proto_err sets (sticky until reset) on any of:
  - A handshake with rid != latched arid.
  - rlast=1 when beat counter != latched arlen.
  - beat counter == arlen on a handshake without rlast.
  - rvalid=1 outside R_DATA.
  - The FSM still returns to IDLE on rlast.
- Simultaneous events:
  - A request that arrives while busy waits.
  - A master deasserting arvalid before grant is legal; no grant is issued.
  - Same-cycle rlast handshake plus a new request: the request is granted the following cycle from IDLE.
- Reset mid-burst: the FSM aborts to IDLE immediately. Outstanding beats arriving after reset raise proto_err, because rvalid is outside R_DATA.

Test Plan:
- inst_arvalid alone, addr 0x1FC0_0000, arlen=15 -> inst_arready pulse, arid=0, arvalid held through 3 arready stall cycles, 16 beats only on inst_rvalid, inst_rlast on beat 16, busy drops, proto_err=0.
- Both arvalid in the same cycle after reset -> inst granted first (arid=0), then data (arid=1, addr 0x8000_0040) after inst's rlast; next tie -> inst again.
- data_rready toggling 0/1 during an 8-beat burst -> rready mirrors it, beat counter advances only on handshakes, completion after 8 handshakes.
- Slave asserts rlast on beat 3 of arlen=7 -> proto_err=1 and stays 1, FSM back in IDLE, next request still served.
- aresetn low during beat 5 of a data burst -> all outputs at reset values asynchronously; after release a new inst request completes normally.
- rid=1 returned for an inst burst -> proto_err=1, data still routed to inst.

Source files
------------

// File: rtl/axi_refill_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_refill_read_arbiter
//
// Shares one AXI3 read port (AR + R channels) between the I-cache and D-cache
// refill engines. Requests are arbitrated round-robin. Only one burst is
// outstanding at a time. The winning request is registered and issued on AR.
// Every R beat is then steered combinationally to the owner until rlast.
//
// Ports
//   aclk, aresetn                  clock, async active-low reset
//   inst_* / data_* ar side        refill requests (valid/addr/len/size) and
//                                  the arready grant pulse back to each engine
//   inst_* / data_* r side         rdata/rresp broadcast; rvalid/rlast go to
//                                  the owner only; *_rready come from the engines
//   ar*                            AR channel to the AXI read master port
//   rid/rdata/rresp/rlast/rvalid   R channel from the slave
//   rready                         owner's rready while a burst is streaming
//   busy                           a burst is in flight (state != IDLE)
//   proto_err                      sticky R-channel protocol error
// ---------------------------------------------------------------------------
module axi_refill_read_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  // I-cache refill request / response
  input  logic        inst_arvalid,
  output logic        inst_arready,
  input  logic [31:0] inst_araddr,
  input  logic [7:0]  inst_arlen,
  input  logic [2:0]  inst_arsize,
  output logic [31:0] inst_rdata,
  output logic [1:0]  inst_rresp,
  output logic        inst_rlast,
  output logic        inst_rvalid,
  input  logic        inst_rready,
  // D-cache refill request / response
  input  logic        data_arvalid,
  output logic        data_arready,
  input  logic [31:0] data_araddr,
  input  logic [7:0]  data_arlen,
  input  logic [2:0]  data_arsize,
  output logic [31:0] data_rdata,
  output logic [1:0]  data_rresp,
  output logic        data_rlast,
  output logic        data_rvalid,
  input  logic        data_rready,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // Status
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AR     = 2'd1,
    R_DATA = 2'd2
  } state_t;

  // Owner / last-grant encoding: 0 = I-cache, 1 = D-cache.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_t      state_r;
  logic        last_grant_r;
  logic        owner_r;
  logic [3:0]  arid_r;
  logic [31:0] araddr_r;
  logic [7:0]  arlen_r;
  logic [2:0]  arsize_r;
  logic        arvalid_r;
  logic [7:0]  beat_cnt_r;
  logic        proto_err_r;

  logic        gnt_inst_s;
  logic        gnt_data_s;
  logic        in_rdata_s;
  logic        owner_rready_s;
  logic        hs_s;
  logic        beat_err_s;
  logic        err_s;

  // Round-robin grant: a lone requester wins, a tie goes to the master that
  // did not win last time. Grants are only issued from IDLE.
  always_comb begin
    gnt_inst_s = 1'b0;
    gnt_data_s = 1'b0;
    if (state_r == IDLE) begin
      if (inst_arvalid && data_arvalid) begin
        if (last_grant_r == OWN_DATA) begin
          gnt_inst_s = 1'b1;
        end else begin
          gnt_data_s = 1'b1;
        end
      end else if (inst_arvalid) begin
        gnt_inst_s = 1'b1;
      end else if (data_arvalid) begin
        gnt_data_s = 1'b1;
      end else begin
        gnt_inst_s = 1'b0;
        gnt_data_s = 1'b0;
      end
    end else begin
      gnt_inst_s = 1'b0;
      gnt_data_s = 1'b0;
    end
  end

  // R-channel steering and protocol-error detection.
  always_comb begin
    in_rdata_s     = (state_r == R_DATA);
    owner_rready_s = (owner_r == OWN_DATA) ? data_rready : inst_rready;
    hs_s           = in_rdata_s & rvalid & owner_rready_s;
    beat_err_s     = 1'b0;
    if (hs_s) begin
      // Wrong id, early/late rlast, or missing rlast on the final beat.
      beat_err_s = (rid != arid_r)
                 | (rlast & (beat_cnt_r != arlen_r))
                 | (~rlast & (beat_cnt_r == arlen_r));
    end else begin
      beat_err_s = 1'b0;
    end
    // A beat while no burst is streaming is always a protocol violation.
    err_s = beat_err_s | (rvalid & ~in_rdata_s);
  end

  // Arbitration FSM: latch the winner, issue AR, count R beats until rlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      last_grant_r <= OWN_DATA;
      owner_r      <= OWN_INST;
      arid_r       <= 4'd0;
      araddr_r     <= 32'd0;
      arlen_r      <= 8'd0;
      arsize_r     <= 3'd0;
      arvalid_r    <= 1'b0;
      beat_cnt_r   <= 8'd0;
      proto_err_r  <= 1'b0;
    end else begin
      if (err_s) begin
        proto_err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (gnt_inst_s || gnt_data_s) begin
            owner_r      <= gnt_data_s;
            last_grant_r <= gnt_data_s;
            arid_r       <= gnt_data_s ? DATA_ID : INST_ID;
            araddr_r     <= gnt_data_s ? data_araddr : inst_araddr;
            arlen_r      <= gnt_data_s ? data_arlen  : inst_arlen;
            arsize_r     <= gnt_data_s ? data_arsize : inst_arsize;
            arvalid_r    <= 1'b1;
            state_r      <= AR;
          end
        end
        AR: begin
          // arvalid stays high with stable fields until the slave accepts.
          if (arready) begin
            arvalid_r  <= 1'b0;
            beat_cnt_r <= 8'd0;
            state_r    <= R_DATA;
          end
        end
        R_DATA: begin
          if (hs_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            // rlast ends the burst even when it arrives on the wrong beat.
            if (rlast) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // The grant pulse is combinational; gating with aresetn keeps it low while
  // reset is held even if requests are already pending.
  assign inst_arready = aresetn & gnt_inst_s;
  assign data_arready = aresetn & gnt_data_s;

  // Data and response fan out to both engines; valid/last reach the owner only.
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign inst_rresp  = rresp;
  assign data_rresp  = rresp;
  assign inst_rvalid = in_rdata_s & (owner_r == OWN_INST) & rvalid;
  assign data_rvalid = in_rdata_s & (owner_r == OWN_DATA) & rvalid;
  assign inst_rlast  = in_rdata_s & (owner_r == OWN_INST) & rlast;
  assign data_rlast  = in_rdata_s & (owner_r == OWN_DATA) & rlast;
  assign rready      = in_rdata_s & owner_rready_s;

  assign arid    = arid_r;
  assign araddr  = araddr_r;
  assign arlen   = arlen_r;
  assign arsize  = arsize_r;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_r;

  assign busy      = (state_r != IDLE);
  assign proto_err = proto_err_r;

endmodule
